// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - program counter with next-PC mode select, stall enable and optional return-address stack
// Optional feature: define PC_RAS_EN to build the circular return-address stack used by CALL/RET.
module pc_unit_ras #(
  parameter int WIDTH     = 32,
  parameter int JADDR_W   = 26,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [2:0]         cnt,
  input  logic [WIDTH-1:0]   pcin,
  input  logic [WIDTH-1:0]   pc0,
  input  logic [JADDR_W-1:0] inst,
  output logic [WIDTH-1:0]   pcout,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_ovf,
  output logic               ras_unf
);

  localparam logic [2:0] M_SEQ    = 3'd0;
  localparam logic [2:0] M_BRANCH = 3'd1;
  localparam logic [2:0] M_JUMP   = 3'd2;
  localparam logic [2:0] M_JREG   = 3'd3;
  localparam logic [2:0] M_CALL   = 3'd4;
  localparam logic [2:0] M_RET    = 3'd5;
  localparam logic [2:0] M_RELOAD = 3'd6;
  localparam logic [2:0] M_HOLD   = 3'd7;

  logic [WIDTH-1:0] p4;
  logic [WIDTH-1:0] boff;
  logic [WIDTH-1:0] jtgt;
  logic [WIDTH-1:0] pc_nxt;

  assign p4   = pcout + WIDTH'(4);
  assign boff = {{(WIDTH-18){inst[15]}}, inst[15:0], 2'b00};
  assign jtgt = {p4[WIDTH-1:JADDR_W+2], inst, 2'b00};

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] ras_top;
  logic             push;
  logic             pop;
  logic             ret_empty;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  assign ras_top   = ras_mem[wptr - PW'(1)];
  assign push      = (cnt == M_CALL);
  assign ret_empty = (cnt == M_RET) && ras_empty;
  assign pop       = (cnt == M_RET) && !ras_empty;

  always_comb begin
    pc_nxt = p4;
    unique case (cnt)
      M_SEQ:    pc_nxt = p4;
      M_BRANCH: pc_nxt = p4 + boff;
      M_JUMP:   pc_nxt = jtgt;
      M_JREG:   pc_nxt = pcin;
      M_CALL:   pc_nxt = jtgt;
      M_RET:    pc_nxt = ras_empty ? pcin : ras_top;
      M_RELOAD: pc_nxt = pc0;
      M_HOLD:   pc_nxt = pcout;
      default:  pc_nxt = p4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcout   <= pc0;
      wptr    <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (wen) begin
      pcout   <= pc_nxt;
      ras_ovf <= push && ras_full;
      ras_unf <= ret_empty;
      if (cnt == M_RELOAD) begin
        wptr  <= '0;
        count <= '0;
      end else if (push) begin
        // a push onto a full stack overwrites the oldest entry, count saturates
        wptr <= wptr + PW'(1);
        if (!ras_full) count <= count + CW'(1);
      end else if (pop) begin
        wptr  <= wptr - PW'(1);
        count <= count - CW'(1);
      end
    end else begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wen && push) ras_mem[wptr] <= p4;
  end
`else
  always_comb begin
    pc_nxt = p4;
    unique case (cnt)
      M_SEQ:    pc_nxt = p4;
      M_BRANCH: pc_nxt = p4 + boff;
      M_JUMP:   pc_nxt = jtgt;
      M_JREG:   pc_nxt = pcin;
      M_CALL:   pc_nxt = jtgt;
      M_RET:    pc_nxt = pcin;
      M_RELOAD: pc_nxt = pc0;
      M_HOLD:   pc_nxt = pcout;
      default:  pc_nxt = p4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      pcout <= pc0;
    else if (wen) pcout <= pc_nxt;
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule
